pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Program-counter register and instruction-fetch sequencer; sits directly downstream of the next-PC logic. Holds CurrentPC, which feeds back to the next-PC logic. Fetches the instruction at CurrentPC over a request/grant/response instruction-memory interface and presents it to decode with a valid/ready handshake. Loads NextPC when decode accepts an instruction. Traps misaligned targets and memory timeouts into a sticky fault state.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset (must be word aligned).
TIMEOUT, 255, maximum wait cycles after grant before a timeout fault (1..65535).

Ports:
CLK  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
NextPC  input  64  next PC from the next-PC logic, sampled only on a decode-accept cycle
CurrentPC  output  64  architectural PC, fed to the next-PC logic and to decode
IMemReq  output  1  fetch request
IMemAddr  output  64  fetch address, equals CurrentPC
IMemGnt  input  1  memory accepted the request this cycle
IMemRspValid  input  1  instruction data valid
IMemRspData  input  32  fetched instruction word
Instruction  output  32  instruction presented to decode
InstrValid  output  1  Instruction is valid
InstrReady  input  1  decode consumes Instruction this cycle
RetiredCount  output  32  count of accepted instructions
Fault  output  1  sticky fault flag
FaultCode  output  2  0 none, 1 misaligned NextPC, 2 memory timeout

Behaviour:
- One clock; reset is synchronous and active-high. Reset dominates in every state.
- On reset: CurrentPC=RESET_PC; state=FETCH_REQ; Instruction=0; RetiredCount=0; Fault=0; FaultCode=0; wait counter=0.
- Outputs IMemReq and InstrValid are decoded from state (Moore). The reset cycle itself drives both low.
- FETCH_REQ:
  - IMemReq=1, IMemAddr=CurrentPC.
  - IMemGnt=1 -> FETCH_WAIT, clear wait counter.
  - IMemRspValid is ignored here, which discards stale responses after reset.
- FETCH_WAIT:
  - IMemReq=0.
  - IMemRspValid=1 -> Instruction<=IMemRspData; go to ISSUE.
  - Otherwise counter+1. When counter reaches TIMEOUT (i.e. TIMEOUT non-responding cycles) -> FAULT, FaultCode=2.
  - Response and timeout in the same cycle: response wins.
- ISSUE:
  - InstrValid=1; Instruction and CurrentPC are held stable until accepted.
  - InstrReady=1 -> CurrentPC<=NextPC; RetiredCount+1 (wraps 32'hFFFFFFFF -> 0).
  - Then NextPC[1:0]!=0 -> FAULT, FaultCode=1. CurrentPC still loads, so it reports the bad target.
  - Otherwise -> FETCH_REQ.
  - InstrReady=0 -> hold state and all values.
- FAULT:
  - IMemReq=0, InstrValid=0, Fault=1.
  - FaultCode, CurrentPC and RetiredCount are frozen.
  - Exits only on Reset.
- Latency:
  - Minimum 3 cycles per instruction: grant in the request cycle, response the next cycle, accept the cycle after.
  - The new PC appears on IMemAddr the cycle after accept.
- Widths: all PC arithmetic is external; the block only registers NextPC. RetiredCount is modulo 2^32.
- IMemGnt is ignored outside FETCH_REQ. IMemRspValid is ignored outside FETCH_WAIT.

Test Plan:
- Reset, then memory grants at once and responds 1 cycle later with 32'h8B020020, decode ready -> IMemAddr=0 on cycle 1; InstrValid on cycle 3 with that word; NextPC=4 accepted; next IMemAddr=4; RetiredCount=1.
- Backpressure: InstrReady held low 5 cycles in ISSUE, NextPC toggling -> Instruction/CurrentPC unchanged; RetiredCount unchanged; after accept, PC = NextPC value of the accept cycle only.
- Branch target NextPC=64'h100 then 64'h102 -> first fetch at 0x100; second accept gives Fault=1, FaultCode=1, CurrentPC=0x102, no further IMemReq.
- Timeout with TIMEOUT=4: grant, no response -> Fault=1, FaultCode=2 on the 4th wait cycle. Response arriving on exactly that cycle instead -> normal ISSUE, no fault.
- Reset asserted in FETCH_WAIT, stale IMemRspValid pulse the cycle after reset -> ignored; fresh request at RESET_PC; Instruction=0, InstrValid=0.
- RetiredCount preset by 2^32-1 accepts (or forced), one more accept -> wraps to 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer.
// It fetches the word at CurrentPC, hands it to decode, then loads NextPC when decode accepts.
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [63:0] NextPC,
  output logic [63:0] CurrentPC,
  output logic        IMemReq,
  output logic [63:0] IMemAddr,
  input  logic        IMemGnt,
  input  logic        IMemRspValid,
  input  logic [31:0] IMemRspData,
  output logic [31:0] Instruction,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] RetiredCount,
  output logic        Fault,
  output logic [1:0]  FaultCode
);

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    ISSUE      = 2'd2,
    FAULT      = 2'd3
  } state_e;

  localparam logic [1:0]  CodeNone      = 2'd0;
  localparam logic [1:0]  CodeMisalign  = 2'd1;
  localparam logic [1:0]  CodeTimeout   = 2'd2;
  // The last wait count before a timeout; the TIMEOUT-th silent cycle trips the fault.
  localparam logic [15:0] WaitLast      = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retiredCount_q, retiredCount_d;
  logic [1:0]  faultCode_q, faultCode_d;
  logic [15:0] waitCnt_q, waitCnt_d;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q        <= FETCH_REQ;
      pc_q           <= RESET_PC;
      instr_q        <= 32'h0;
      retiredCount_q <= 32'h0;
      faultCode_q    <= CodeNone;
      waitCnt_q      <= 16'h0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      retiredCount_q <= retiredCount_d;
      faultCode_q    <= faultCode_d;
      waitCnt_q      <= waitCnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    retiredCount_d = retiredCount_q;
    faultCode_d    = faultCode_q;
    waitCnt_d      = waitCnt_q;

    unique case (state_q)
      FETCH_REQ: begin
        if (IMemGnt) begin
          state_d   = FETCH_WAIT;
          waitCnt_d = 16'h0;
        end
      end
      FETCH_WAIT: begin
        // A response arriving on the timeout cycle still wins.
        if (IMemRspValid) begin
          instr_d = IMemRspData;
          state_d = ISSUE;
        end else begin
          waitCnt_d = waitCnt_q + 16'd1;
          if (waitCnt_q == WaitLast) begin
            state_d     = FAULT;
            faultCode_d = CodeTimeout;
          end
        end
      end
      ISSUE: begin
        if (InstrReady) begin
          pc_d           = NextPC;
          retiredCount_d = retiredCount_q + 32'd1;
          if (NextPC[1:0] != 2'b00) begin
            state_d     = FAULT;
            faultCode_d = CodeMisalign;
          end else begin
            state_d = FETCH_REQ;
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: state_d = FETCH_REQ;
    endcase
  end

  // Handshake outputs are forced low while Reset is held, whatever the old state was.
  assign IMemReq      = (state_q == FETCH_REQ) && !Reset;
  assign InstrValid   = (state_q == ISSUE) && !Reset;
  assign IMemAddr     = pc_q;
  assign CurrentPC    = pc_q;
  assign Instruction  = instr_q;
  assign RetiredCount = retiredCount_q;
  assign Fault        = (state_q == FAULT);
  assign FaultCode    = faultCode_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit, built with TIMEOUT=4 so the timeout path is reachable quickly.
module tb_pc_fetch_unit;

  logic        CLK;
  logic        Reset;
  logic [63:0] NextPC;
  logic [63:0] CurrentPC;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemGnt;
  logic        IMemRspValid;
  logic [31:0] IMemRspData;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] RetiredCount;
  logic        Fault;
  logic [1:0]  FaultCode;

  int compared   = 0;
  int mismatched = 0;

  pc_fetch_unit #(
    .RESET_PC(64'h0),
    .TIMEOUT (4)
  ) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .NextPC      (NextPC),
    .CurrentPC   (CurrentPC),
    .IMemReq     (IMemReq),
    .IMemAddr    (IMemAddr),
    .IMemGnt     (IMemGnt),
    .IMemRspValid(IMemRspValid),
    .IMemRspData (IMemRspData),
    .Instruction (Instruction),
    .InstrValid  (InstrValid),
    .InstrReady  (InstrReady),
    .RetiredCount(RetiredCount),
    .Fault       (Fault),
    .FaultCode   (FaultCode)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one cycle of inputs, clock once, and settle 1 time unit past the edge.
  task automatic applyStimulus(input logic gnt, input logic rsp, input logic [31:0] data,
                               input logic ready, input logic [63:0] npc);
    IMemGnt      = gnt;
    IMemRspValid = rsp;
    IMemRspData  = data;
    InstrReady   = ready;
    NextPC       = npc;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    Reset = 1'b1;
    IMemGnt = 1'b0; IMemRspValid = 1'b0; IMemRspData = 32'h0; InstrReady = 1'b0; NextPC = 64'h0;

    // Reset cycle drives handshakes low, then the reset values appear.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
    checkOutput("rst_req_low",   64'(IMemReq),    64'd0);
    checkOutput("rst_valid_low", 64'(InstrValid), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
    checkOutput("rst_pc",      CurrentPC,          64'h0);
    checkOutput("rst_retired", 64'(RetiredCount),  64'd0);
    checkOutput("rst_fault",   64'(Fault),         64'd0);
    checkOutput("rst_code",    64'(FaultCode),     64'd0);
    checkOutput("rst_instr",   64'(Instruction),   64'h0);
    Reset = 1'b0;
    #1;

    // Basic fetch: grant at once, response next cycle, accept with NextPC=4.
    checkOutput("t1_req",  64'(IMemReq), 64'd1);
    checkOutput("t1_addr", IMemAddr,     64'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0);
    checkOutput("t1_wait_req",   64'(IMemReq),    64'd0);
    checkOutput("t1_wait_valid", 64'(InstrValid), 64'd0);
    applyStimulus(1'b0, 1'b1, 32'h8B020020, 1'b0, 64'h0);
    checkOutput("t1_valid", 64'(InstrValid),  64'd1);
    checkOutput("t1_instr", 64'(Instruction), 64'h8B020020);
    checkOutput("t1_pc",    CurrentPC,        64'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 64'h4);
    checkOutput("t1_next_addr", IMemAddr,          64'h4);
    checkOutput("t1_next_req",  64'(IMemReq),      64'd1);
    checkOutput("t1_retired",   64'(RetiredCount), 64'd1);
    checkOutput("t1_valid_off", 64'(InstrValid),   64'd0);

    // Backpressure: five stalled cycles with NextPC changing underneath.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 32'h12345678, 1'b0, 64'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, (i % 2 == 0) ? 64'h200 + 64'(i * 4) : 64'h3);
      checkOutput("t2_hold_instr",   64'(Instruction),  64'h12345678);
      checkOutput("t2_hold_pc",      CurrentPC,         64'h4);
      checkOutput("t2_hold_retired", 64'(RetiredCount), 64'd1);
      checkOutput("t2_hold_valid",   64'(InstrValid),   64'd1);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 64'h100);
    checkOutput("t2_pc",      CurrentPC,         64'h100);
    checkOutput("t2_retired", 64'(RetiredCount), 64'd2);

    // Branch to 0x100, then a misaligned target 0x102 traps.
    checkOutput("t3_addr", IMemAddr, 64'h100);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 32'hA5A50001, 1'b0, 64'h0);
    checkOutput("t3_instr", 64'(Instruction), 64'hA5A50001);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 64'h102);
    checkOutput("t3_fault",   64'(Fault),        64'd1);
    checkOutput("t3_code",    64'(FaultCode),    64'd1);
    checkOutput("t3_pc",      CurrentPC,         64'h102);
    checkOutput("t3_req",     64'(IMemReq),      64'd0);
    checkOutput("t3_retired", 64'(RetiredCount), 64'd3);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 64'h4);
      checkOutput("t3_stuck_req",     64'(IMemReq),      64'd0);
      checkOutput("t3_stuck_valid",   64'(InstrValid),   64'd0);
      checkOutput("t3_stuck_code",    64'(FaultCode),    64'd1);
      checkOutput("t3_stuck_pc",      CurrentPC,         64'h102);
      checkOutput("t3_stuck_retired", 64'(RetiredCount), 64'd3);
    end

    // Timeout: grant, then four silent wait cycles.
    Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
    Reset = 1'b0;
    #1;
    checkOutput("t4_rst_fault",   64'(Fault),        64'd0);
    checkOutput("t4_rst_code",    64'(FaultCode),    64'd0);
    checkOutput("t4_rst_pc",      CurrentPC,         64'h0);
    checkOutput("t4_rst_retired", 64'(RetiredCount), 64'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t4_no_fault_yet", 64'(Fault), 64'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
    end
    checkOutput("t4_timeout_fault", 64'(Fault),     64'd1);
    checkOutput("t4_timeout_code",  64'(FaultCode), 64'd2);
    checkOutput("t4_timeout_req",   64'(IMemReq),   64'd0);

    // Response on exactly the timeout cycle wins.
    Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
    Reset = 1'b0;
    #1;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b1, 32'hCAFE0004, 1'b0, 64'h0);
    checkOutput("t4_late_fault", 64'(Fault),       64'd0);
    checkOutput("t4_late_code",  64'(FaultCode),   64'd0);
    checkOutput("t4_late_valid", 64'(InstrValid),  64'd1);
    checkOutput("t4_late_instr", 64'(Instruction), 64'hCAFE0004);

    // Reset in FETCH_WAIT followed by a stale response pulse.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 64'h8);
    checkOutput("t5_addr8", IMemAddr, 64'h8);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0);
    Reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
    Reset = 1'b0;
    #1;
    checkOutput("t5_req",     64'(IMemReq),      64'd1);
    checkOutput("t5_addr",    IMemAddr,          64'h0);
    checkOutput("t5_instr",   64'(Instruction),  64'h0);
    checkOutput("t5_retired", 64'(RetiredCount), 64'd0);
    applyStimulus(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 64'h0);
    checkOutput("t5_stale_req",   64'(IMemReq),     64'd1);
    checkOutput("t5_stale_valid", 64'(InstrValid),  64'd0);
    checkOutput("t5_stale_instr", 64'(Instruction), 64'h0);
    checkOutput("t5_stale_addr",  IMemAddr,         64'h0);

    // RetiredCount wraps from all-ones to zero on the next accept.
    force dut.retiredCount_q = 32'hFFFFFFFF;
    #1;
    release dut.retiredCount_q;
    #1;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 64'h0);
    checkOutput("t6_preset", 64'(RetiredCount), 64'hFFFFFFFF);
    applyStimulus(1'b0, 1'b1, 32'h00000013, 1'b0, 64'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 64'hC);
    checkOutput("t6_wrap", 64'(RetiredCount), 64'd0);
    checkOutput("t6_pc",   CurrentPC,         64'hC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
